// File: rtl/mmio_peripheral_block_if.sv
// Core write-path types plus the MMIO bus between hart and peripheral: request in,
// same-cycle completion and combinational status word back.
package mmio_pkg;
   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      write_byte = 2'd0,
      write_half = 2'd1,
      write_word = 2'd2
   } write_width_t;

   typedef struct packed {
      logic             enable;
      logic [XLEN-1:0]  addr;
      write_width_t     width;
      logic [XLEN-1:0]  value;
   } mem_write_control_t;
endpackage

interface mmio_peripheral_block_if;
   import mmio_pkg::*;

   mem_write_control_t memory_mapped_io_control;
   logic               memory_mapped_io_write_complete;
   logic [XLEN-1:0]    memory_mapped_io_r_data;

   modport master (
      output memory_mapped_io_control,
      input  memory_mapped_io_write_complete,
      input  memory_mapped_io_r_data
   );

   modport slave (
      input  memory_mapped_io_control,
      output memory_mapped_io_write_complete,
      output memory_mapped_io_r_data
   );
endinterface

// File: rtl/mmio_peripheral_block.sv
// MMIO peripheral: TX byte FIFO, LED registers, sticky-flag STATUS. Writes complete the
// same cycle; a full FIFO stalls TXDATA byte writes (blocking) or drops them (overflow).
module mmio_peripheral_block
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0003_0000,
   parameter int          NUM_LEDS    = 2,
   parameter int          TX_DEPTH    = 8,
   parameter bit          TX_BLOCKING = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   mmio_peripheral_block_if.slave  mmio,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [NUM_LEDS-1:0]     led_control
);
   localparam int PTR_W = $clog2(TX_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   mem_write_control_t ctl;
   logic [7:0]         fifo_mem [TX_DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [LVL_W-1:0]   level;
   logic               overflow;
   logic               width_err;

   logic               in_window;
   logic               hit;
   logic [7:0]         offset;
   logic               tx_sel;
   logic               status_sel;
   logic               byte_write;
   logic               fifo_full;
   logic               fifo_empty;
   logic               stall;
   logic               push;
   logic               pop;
   logic [XLEN-1:0]    status_word;

   assign ctl        = mmio.memory_mapped_io_control;
   assign in_window  = ctl.addr[31:8] == BASE_ADDR[31:8];
   assign hit        = ctl.enable && in_window;
   assign offset     = ctl.addr[7:0];
   assign tx_sel     = hit && (offset == 8'h00);
   assign status_sel = hit && (offset == 8'h40);
   assign byte_write = tx_sel && (ctl.width == write_byte);

   // Full comes from the registered level only, so a pop never frees a slot same-cycle.
   assign fifo_full  = level == LVL_W'(TX_DEPTH);
   assign fifo_empty = level == '0;
   assign stall      = byte_write && fifo_full && TX_BLOCKING;
   assign push       = byte_write && !fifo_full;
   assign pop        = tx_valid && tx_ready;

   assign mmio.memory_mapped_io_write_complete = hit && !stall;

   assign status_word = {15'd0, 9'(level), 4'd0, width_err, overflow, fifo_full, fifo_empty};
   assign mmio.memory_mapped_io_r_data = (in_window && offset == 8'h40) ? status_word : '0;

   assign tx_valid = !fifo_empty;
   assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= ctl.value[7:0];
   end

   // Sticky flags: a set wins over a clear arriving in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow    <= 1'b0;
         width_err   <= 1'b0;
         led_control <= '0;
      end else begin
         if (byte_write && fifo_full && !TX_BLOCKING) overflow <= 1'b1;
         else if (status_sel && ctl.value[2])         overflow <= 1'b0;

         if (tx_sel && ctl.width != write_byte)  width_err <= 1'b1;
         else if (status_sel && ctl.value[3])    width_err <= 1'b0;

         for (int i = 0; i < NUM_LEDS; i++) begin
            if (hit && offset == 8'(4 + 4 * i)) led_control[i] <= (ctl.value != '0);
         end
      end
   end
endmodule
